ins_fetch_queue: RTL and testbench

//  Instruction fetch front end, directly upstream of the memory controller's instruction port.

---
 rtl/ins_fetch_queue.sv | 130 +++++++++++++
 tb/tb_ins_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_queue.sv
// Instruction fetch front end: one outstanding 4-byte fetch, results buffered {pc, ins} in an in-order FIFO.
// Latency: request strobe in the first IDLE cycle with space; entry visible at issue_* the cycle after ok.
// Backpressure: no request while full or waiting on memctrl; rdy=0 freezes all state, Clear_flag flushes.
module ins_fetch_queue #(
    parameter int          QDEPTH_LOG2 = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   Clear_flag,
    input  logic [31:0]            clear_pc,
    output logic                   insqueue_to_memctrl_needchange,
    output logic [31:0]            memctrl_ins_addr_,
    output logic [3:0]             memctrl_ins_remain_cycle_,
    input  logic                   memctrl_ins_ok__,
    input  logic [31:0]            memctrl_ins_ans__,
    output logic                   issue_valid,
    output logic [31:0]            issue_ins,
    output logic [31:0]            issue_pc,
    input  logic                   issue_ready,
    output logic [QDEPTH_LOG2:0]   queue_count
);

    localparam int                  DEPTH     = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0] DEPTH_CNT = (QDEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    state_t                 state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [QDEPTH_LOG2-1:0] head_q, head_d;
    logic [QDEPTH_LOG2-1:0] tail_q, tail_d;
    logic [QDEPTH_LOG2:0]   count_q, count_d;
    entry_t                 mem_q [DEPTH];
    entry_t                 wr_dat_d;
    entry_t                 head_ent;

    logic active;
    logic req;
    logic push;
    logic pop;

    always_comb begin
        active = rdy && !Clear_flag;
        // The space check at request time guarantees room when the answer arrives.
        req    = rst && active && (state_q == S_IDLE) && (count_q < DEPTH_CNT);
        push   = active && (state_q == S_WAIT) && memctrl_ins_ok__;
        pop    = active && (count_q != '0) && issue_ready;

        wr_dat_d.pc  = fetch_pc_q;
        wr_dat_d.ins = memctrl_ins_ans__;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (rdy) begin
            if (Clear_flag) begin
                state_d    = S_IDLE;
                fetch_pc_d = clear_pc;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end else begin
                if (req) begin
                    state_d = S_WAIT;
                end
                if (push) begin
                    state_d    = S_IDLE;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    tail_d     = tail_q + QDEPTH_LOG2'(1);
                end
                if (pop) begin
                    head_d = head_q + QDEPTH_LOG2'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + (QDEPTH_LOG2 + 1)'(1);
                    2'b01:   count_d = count_q - (QDEPTH_LOG2 + 1)'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= wr_dat_d;
        end
    end

    always_comb begin
        head_ent                       = mem_q[head_q];
        insqueue_to_memctrl_needchange = req;
        memctrl_ins_addr_              = rst ? fetch_pc_q : 32'h0;
        memctrl_ins_remain_cycle_      = rst ? 4'd4 : 4'd0;
        issue_valid                    = rst && (count_q != '0);
        issue_ins                      = issue_valid ? head_ent.ins : 32'h0;
        issue_pc                       = issue_valid ? head_ent.pc : 32'h0;
        queue_count                    = count_q;
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Scoreboard bench for ins_fetch_queue: driver plays memctrl and consumer, monitor checks every pop.
module tb_ins_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        Clear_flag = 1'b0;
    logic [31:0] clear_pc = 32'h0;
    logic        needchange;
    logic [31:0] addr;
    logic [3:0]  remain;
    logic        ok = 1'b0;
    logic [31:0] ans = 32'h0;
    logic        issue_valid;
    logic [31:0] issue_ins;
    logic [31:0] issue_pc;
    logic        issue_ready = 1'b0;
    logic [4:0]  queue_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    logic [63:0] mon_e;
    logic [31:0] exp_pc = 32'h0;

    always #5 clk = ~clk;

    ins_fetch_queue #(.QDEPTH_LOG2(4), .RESET_PC(32'h0)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .rdy                            (rdy),
        .Clear_flag                     (Clear_flag),
        .clear_pc                       (clear_pc),
        .insqueue_to_memctrl_needchange (needchange),
        .memctrl_ins_addr_              (addr),
        .memctrl_ins_remain_cycle_      (remain),
        .memctrl_ins_ok__               (ok),
        .memctrl_ins_ans__              (ans),
        .issue_valid                    (issue_valid),
        .issue_ins                      (issue_ins),
        .issue_pc                       (issue_pc),
        .issue_ready                    (issue_ready),
        .queue_count                    (queue_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that accepts the request.
    task automatic wait_req(input logic [31:0] a, input int max_wait, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (needchange === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({nm, "_strobe"}, 32'(found), 32'd1);
        if (found) begin
            chk({nm, "_addr"}, addr, a);
            chk({nm, "_remain"}, 32'(remain), 32'd4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a_ins, input int lat);
        repeat (lat) tick();
        ok  = 1'b1;
        ans = a_ins;
        sb.push_back({exp_pc, a_ins});
        tick();
        ok     = 1'b0;
        exp_pc = exp_pc + 32'd4;
    endtask

    always @(negedge clk) begin
        if (rst && rdy && !Clear_flag && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc 0x%08h, expected no entry", issue_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_pc", issue_pc, mon_e[63:32]);
                chk("pop_ins", issue_ins, mon_e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "timeout");
    end

    initial begin
        int strobes;

        #2;
        chk("rst_needchange", 32'(needchange), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_remain", 32'(remain), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: first fetch at RESET_PC
        wait_req(32'h0, 3, "t1_req0");
        @(negedge clk);
        chk("t1_strobe_one_cycle", 32'(needchange), 32'd0);
        @(posedge clk);
        #1;
        fetch(32'h0000_0093, 4);
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_pc", issue_pc, 32'h0);
        chk("t1_ins", issue_ins, 32'h0000_0093);
        wait_req(32'h4, 1, "t1_req4");
        fetch(32'hA000_0004, 1);

        // 2: fill to 16 with no consumer
        for (int i = 0; i < 14; i++) begin
            wait_req(exp_pc, 3, "t2_fill");
            fetch(32'hA000_0000 | exp_pc, i % 3);
        end
        chk("t2_count_full", 32'(queue_count), 32'd16);
        strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (needchange) strobes++;
        end
        chk("t2_no_strobe_full", 32'(strobes), 32'd0);
        @(posedge clk);
        #1;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t2_count_after_pop", 32'(queue_count), 32'd15);
        wait_req(32'h40, 1, "t2_req40");
        fetch(32'hA000_0040, 2);
        chk("t2_count_refill", 32'(queue_count), 32'd16);

        // 3: clear in WAIT with a simultaneous ok
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        wait_req(32'h44, 1, "t3_req44");
        tick();
        Clear_flag = 1'b1;
        clear_pc   = 32'h100;
        ok         = 1'b1;
        ans        = 32'hDEAD_0044;
        tick();
        Clear_flag = 1'b0;
        ok         = 1'b0;
        sb.delete();
        chk("t3_count_cleared", 32'(queue_count), 32'd0);
        chk("t3_valid_cleared", 32'(issue_valid), 32'd0);
        exp_pc = 32'h100;
        wait_req(32'h100, 1, "t3_req100");

        // 4: push and pop in the same cycle, then run across pointer wrap
        fetch(32'h0000_0013, 3);
        chk("t4_count1", 32'(queue_count), 32'd1);
        wait_req(32'h104, 1, "t4_req104");
        tick();
        ok          = 1'b1;
        ans         = 32'h0040_0113;
        issue_ready = 1'b1;
        sb.push_back({32'h104, 32'h0040_0113});
        tick();
        ok          = 1'b0;
        issue_ready = 1'b0;
        exp_pc      = 32'h108;
        chk("t4_count_same", 32'(queue_count), 32'd1);
        chk("t4_head_pc", issue_pc, 32'h104);
        chk("t4_head_ins", issue_ins, 32'h0040_0113);
        issue_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_req(exp_pc, 3, "t4_wrap");
            fetch(32'hC000_0000 | exp_pc, i % 4);
        end

        // 5: rdy low in IDLE with space
        rdy = 1'b0;
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (needchange) strobes++;
            chk("t5_count_frozen", 32'(queue_count), 32'd1);
        end
        chk("t5_no_strobe", 32'(strobes), 32'd0);
        @(posedge clk);
        #1;
        rdy = 1'b1;
        wait_req(32'h158, 1, "t5_resume");

        // 6: async reset in WAIT
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_needchange", 32'(needchange), 32'd0);
        chk("t6_addr", addr, 32'h0);
        chk("t6_remain", 32'(remain), 32'd0);
        chk("t6_valid", 32'(issue_valid), 32'd0);
        chk("t6_count", 32'(queue_count), 32'd0);
        chk("t6_ins", issue_ins, 32'h0);
        chk("t6_pc", issue_pc, 32'h0);
        sb.delete();
        issue_ready = 1'b0;
        exp_pc      = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ok  = 1'b1;
        ans = 32'hBAD0_BAD0;
        wait_req(32'h0, 1, "t6_restart");
        ok = 1'b0;
        chk("t6_stray_ok_count", 32'(queue_count), 32'd0);
        fetch(32'h0000_0537, 2);
        chk("t6_pc_after", issue_pc, 32'h0);
        chk("t6_ins_after", issue_ins, 32'h0000_0537);

        issue_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sb.size() == 0 && queue_count == 5'd0) break;
        end
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_count", 32'(queue_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
